traffic_light_arbiter: RTL and testbench
========================================

// Module: traffic_light_arbiter
// PURPOSE
//  Parametrised N-approach traffic-light controller. One green at a time, granted round-robin among
//  approaches with a car present. Phases are timed: minimum green, maximum green under contention, then yellow.
//  Standalone intersection core that the system stimulates with sensor inputs.
// PARAMETERS
//  N_APPROACH     4   number of approaches (>=2)
//  TIMER_W        8   phase counter width; must hold MAX_GREEN and ALL_RED_CYCLES
//  MIN_GREEN      4   minimum green cycles (>=1)
//  MAX_GREEN      16  green cycles before forced handover when another approach waits (>=MIN_GREEN)
//  YELLOW_CYCLES  3   yellow duration in cycles (>=1)
//  ALL_RED_CYCLES 2   clearance duration (used only with ALL_RED_CLEAR_EN; >=1)
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               asynchronous, active-low reset
//  car_detected  in   N_APPROACH      level car-present per approach, sampled at clk
//  light_state   out  2*N_APPROACH    per approach [2i+1:2i]: 00 RED, 01 GREEN, 10 YELLOW (11 never driven)
//  grant_idx     out  $clog2(N)       approach currently or last owning green/yellow
//  timer_expired out  1               one-cycle pulse on the cycle after a timed phase ends
// BEHAVIOUR
//  - Reset (reset=0): immediately and asynchronously state=IDLE, light_state all RED, grant_idx=0,
//    timer_expired=0, rr pointer=N-1 (approach 0 wins first). Reset mid-phase aborts the phase.
//  - All outputs registered. Request seen at edge k in IDLE gives GREEN visible after edge k (1-cycle latency).
//  - FSM: IDLE -> GREEN -> YELLOW -> [CLEAR] -> IDLE.
//    IDLE: all RED. Any car_detected -> GREEN for the round-robin winner, load grant_idx, clear counter.
//      The winner is the first requester after the last served index, wrapping N-1 -> 0.
//    GREEN: counter increments each cycle and saturates at 2^TIMER_W-1.
//      Exit to YELLOW when cnt>=MIN_GREEN-1 AND (!car_detected[g] OR (other req AND cnt>=MAX_GREEN-1)).
//      With a lone requester the green is held indefinitely: no yellow, no timer_expired.
//    YELLOW: exactly YELLOW_CYCLES cycles, then IDLE (or CLEAR). Request changes are ignored.
//    CLEAR: ALL_RED_CYCLES all-RED cycles, then IDLE.
//  - Every phase exit is one registered transition. timer_expired=1 for the one cycle after that edge.
//  - IDLE always lasts >=1 cycle, so successive greens are separated by at least one all-RED cycle.
//  - Rr pointer updates only on entry to GREEN. Approaches dropping request before being served are skipped.
//  - Exactly zero or one approach is non-RED at any cycle (invariant).
// CONFIGURATION
//  ALL_RED_CLEAR_EN defined: YELLOW -> CLEAR (ALL_RED_CYCLES all-RED) -> IDLE.
//  Undefined: YELLOW -> IDLE directly. CLEAR state and ALL_RED_CYCLES are unused and compiled out.
// STRUCTURE
//  traffic_pkg: light_t (RED=2'b00, GREEN=2'b01, YELLOW=2'b10), state_t (IDLE, GREEN, YELLOW, CLEAR).
//  Sub-module rr_arbiter: combinational; inputs are req[N] and last index, outputs are any_req and winner index.
//  Top holds the FSM, phase counter, pointer and output registers.
// TESTING (defaults, 10 ns clock)
//  1. reset=0 for 2 cycles -> light_state=8'h00, grant_idx=0, timer_expired=0. Async: outputs clear before the next edge.
//  2. car_detected=4'b0100 for 2 cycles then 0 -> light_state=8'h10 for 4 cycles, then 8'h20 for 3 cycles, then 8'h00.
//     timer_expired pulses after each phase end.
//  3. car_detected=4'b0001 constant for 40 cycles -> light_state=8'h01 throughout, no timer_expired.
//  4. car_detected=4'b0011 constant -> approach 0 green 16, yellow 3, [clear 2], 1 idle, then approach 1.
//     grant_idx sequence 0,1,0,1.
//  5. car_detected=4'b1111 constant -> grant order 0,1,2,3,0. Never more than one non-RED field.
//  6. reset pulsed low mid-GREEN of approach 2 -> all RED immediately. After release with 4'b0100, approach 2
//     green 1 cycle later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light arbiter: per-approach light encoding and FSM states.
package traffic_pkg;

    typedef enum logic [1:0] {
        LightRed    = 2'b00,
        LightGreen  = 2'b01,
        LightYellow = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StYellow,
        StClear
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_i, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic            any_req_o,
    output logic [IdxW-1:0] winner_o
);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        any_req_o = |req_i;
        winner_o  = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IdxW'((32'(last_i) + i) % N);
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_light_arbiter.sv
// N-approach traffic-light controller: round-robin green, min/max green timing, then yellow.
// Define ALL_RED_CLEAR_EN to insert an all-red clearance phase between yellow and idle.
module traffic_light_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned N_APPROACH     = 4,
    parameter int unsigned TIMER_W        = 8,
    parameter int unsigned MIN_GREEN      = 4,
    parameter int unsigned MAX_GREEN      = 16,
    parameter int unsigned YELLOW_CYCLES  = 3,
    parameter int unsigned ALL_RED_CYCLES = 2,
    localparam int unsigned IdxW          = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_APPROACH-1:0]   car_detected,
    output logic [2*N_APPROACH-1:0] light_state,
    output logic [IdxW-1:0]         grant_idx,
    output logic                    timer_expired
);

    if (N_APPROACH < 2 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_CYCLES < 1 ||
        ALL_RED_CYCLES < 1) begin : g_param_check
        $error("traffic_light_arbiter: illegal parameter combination");
    end

    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]         grant_q, grant_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [2*N_APPROACH-1:0] light_q, light_d;
    logic                    expired_q, expired_d;

    logic                    any_req;
    logic [IdxW-1:0]         winner;
    logic [N_APPROACH-1:0]   grant_mask;
    logic                    others_req;
    logic [TIMER_W-1:0]      cnt_inc;

    rr_arbiter #(
        .N    (N_APPROACH),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i     (car_detected),
        .last_i    (ptr_q),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        expired_d  = 1'b0;
        light_d    = '0;
        grant_mask = '0;
        grant_mask[grant_q] = 1'b1;
        others_req = |(car_detected & ~grant_mask);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StGreen;
                    grant_d = winner;
                    ptr_d   = winner;
                    cnt_d   = '0;
                end
            end
            StGreen: begin
                if (cnt_q >= TIMER_W'(MIN_GREEN - 1) &&
                    (!car_detected[grant_q] ||
                     (others_req && cnt_q >= TIMER_W'(MAX_GREEN - 1)))) begin
                    state_d   = StYellow;
                    cnt_d     = '0;
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StYellow: begin
                if (cnt_q == TIMER_W'(YELLOW_CYCLES - 1)) begin
`ifdef ALL_RED_CLEAR_EN
                    state_d   = StClear;
`else
                    state_d   = StIdle;
`endif
                    cnt_d     = '0;
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef ALL_RED_CLEAR_EN
            StClear: begin
                if (cnt_q == TIMER_W'(ALL_RED_CYCLES - 1)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Lights follow the next state so they change on the same edge as the FSM.
        for (int unsigned i = 0; i < N_APPROACH; i++) begin
            if (IdxW'(i) == grant_d && state_d == StGreen) begin
                light_d[2*i +: 2] = LightGreen;
            end else if (IdxW'(i) == grant_d && state_d == StYellow) begin
                light_d[2*i +: 2] = LightYellow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_q   <= '0;
            ptr_q     <= IdxW'(N_APPROACH - 1);
            light_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            light_q   <= light_d;
            expired_q <= expired_d;
        end
    end

    assign light_state   = light_q;
    assign grant_idx     = grant_q;
    assign timer_expired = expired_q;

endmodule

// File: tb/tb_traffic_light_arbiter.sv
// Randomised bench for traffic_light_arbiter against a phase/age reference model.
module tb_traffic_light_arbiter;

    localparam int N      = 4;
    localparam int TW     = 8;
    localparam int MIN_G  = 4;
    localparam int MAX_G  = 16;
    localparam int YEL    = 3;
    localparam int ALLRED = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] car = '0;
    logic [2*N-1:0] light_state;
    logic [1:0]   grant_idx;
    logic         timer_expired;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 green, 2 yellow, 3 all-red clearance.
    int m_ph, m_owner, m_ptr, m_age, m_left;
    bit m_exp;

    traffic_light_arbiter #(
        .N_APPROACH     (N),
        .TIMER_W        (TW),
        .MIN_GREEN      (MIN_G),
        .MAX_GREEN      (MAX_G),
        .YELLOW_CYCLES  (YEL),
        .ALL_RED_CYCLES (ALLRED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .car_detected  (car),
        .light_state   (light_state),
        .grant_idx     (grant_idx),
        .timer_expired (timer_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_owner = 0; m_ptr = N - 1; m_age = 0; m_left = 0; m_exp = 0;
    endtask

    task automatic model_step(input logic [N-1:0] pat);
        logic [N-1:0] mask;
        int w;
        m_exp = 0;
        case (m_ph)
            0: begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (w < 0 && pat[idx]) w = idx;
                end
                if (w >= 0) begin
                    m_ph = 1; m_owner = w; m_ptr = w; m_age = 1;
                end
            end
            1: begin
                mask = '0;
                mask[m_owner] = 1'b1;
                if (m_age >= MIN_G &&
                    (!pat[m_owner] || ((pat & ~mask) != 0 && m_age >= MAX_G))) begin
                    m_ph = 2; m_left = YEL; m_exp = 1;
                end else begin
                    m_age++;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
`ifdef ALL_RED_CLEAR_EN
                    m_ph = 3; m_left = ALLRED;
`else
                    m_ph = 0;
`endif
                    m_exp = 1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_ph = 0; m_exp = 1;
                end
            end
        endcase
    endtask

    task automatic compare_outputs();
        logic [2*N-1:0] e;
        int nonred;
        e = '0;
        if (m_ph == 1) e[2*m_owner +: 2] = 2'b01;
        if (m_ph == 2) e[2*m_owner +: 2] = 2'b10;
        check("light_state", 32'(light_state), 32'(e));
        check("grant_idx", 32'(grant_idx), 32'(m_owner));
        check("timer_expired", 32'(timer_expired), 32'(m_exp));
        nonred = 0;
        for (int i = 0; i < N; i++) if (light_state[2*i +: 2] != 2'b00) nonred++;
        check("one_non_red", 32'(nonred <= 1), 32'd1);
        check("no_code_11", 32'((light_state & (light_state >> 1) & 8'h55) != 0), 32'd0);
    endtask

    // Called at a negedge; applies pat for one clock and checks at the following negedge.
    task automatic cycle(input logic [N-1:0] pat);
        car = pat;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(pat);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input logic [N-1:0] pat, input int n);
        for (int i = 0; i < n; i++) cycle(pat);
    endtask

    // Asynchronous reset between edges: outputs must clear before the next edge.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_light", 32'(light_state), 32'd0);
        check("async_grant", 32'(grant_idx), 32'd0);
        check("async_expired", 32'(timer_expired), 32'd0);
        @(negedge clk);
        run(car, 1);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        run('0, 2);
        reset = 1'b1;

        run(4'b0100, 2);
        run(4'b0000, 12);
        run(4'b0001, 40);
        run(4'b0000, 10);
        run(4'b0011, 90);
        run(4'b0000, 10);
        run(4'b1111, 120);
        run(4'b0000, 10);

        run(4'b0100, 3);
        pulse_reset();
        run(4'b0100, 8);
        run(4'b0000, 10);

        for (int s = 0; s < 250; s++) begin
            logic [N-1:0] pat;
            pat = N'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) pulse_reset();
            run(pat, int'($urandom_range(1, 25)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
